mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle MIPS control unit that replaces the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and waits on a ready handshake from the shared instruction/data memory. It drives the same datapath control set as the single-cycle decoder, plus PC, IR and address-select strobes, and keeps a retired-instruction counter. It sits between the IR and the multi-cycle datapath.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- opc  in  6  opcode field from the IR
- func  in  6  function field from the IR
- memReady  in  1  memory has completed the current access
- pcWrite, irWrite  out  1  PC / IR load strobes
- pcSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- memAddrSel  out  1  0 = PC, 1 = ALU result
- memRead, memWrite  out  1  memory strobes, held until memReady
- isJmp, isBeq, isBne  out  1  branch/jump qualifiers
- rfWriteDataSel  out  2  00 = ALU, 01 = memory
- rfWriteAddrSel  out  1  1 = rd, 0 = rt
- rfWriteEnable  out  1  register-file write
- aluSrcA  out  1  0 = PC, 1 = rs
- aluSrcB  out  2  00 = rt, 01 = const 4, 10 = immediate
- aluFunc  out  3  `ALU_*` code
- bitXtend  out  1  1 = sign-extend immediate, 0 = zero-extend
- invOpcode  out  1  one-cycle pulse on an undecodable opc/func
- retire  out  1  one-cycle pulse when an instruction completes
- instCount  out  CNT_W  number of retired instructions
- state  out  3  current state (debug)

## Operation
- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Every output not listed as active for a state is driven 0. There are no X outputs.
- **FETCH**
  - Drives memRead = 1, memAddrSel = 0.
  - While memReady = 0, stays in FETCH with irWrite = 0 and pcWrite = 0.
  - When memReady = 1, drives irWrite = 1, pcWrite = 1, pcSrc = 00, aluSrcA = 0, aluSrcB = 01, aluFunc = `ALU_ADD`, then goes to DECODE.
- **DECODE**
  - Captures opc/func into internal registers. Later states use only the captured copy.
  - Supported: R-type (opc 0) with func `MIPS_ADD`/`MIPS_SUB`/`MIPS_AND`/`MIPS_OR`/`MIPS_SLT`; `MIPS_LW`, `MIPS_SW`, `MIPS_BEQ`, `MIPS_BNE`, `MIPS_J`, `MIPS_ADDI`, `MIPS_ANDI`, `MIPS_ORI`.
  - J: drives isJmp = 1, pcWrite = 1, pcSrc = 10, retire, then goes to FETCH.
  - Invalid opc/func: pulses invOpcode, then handled per Configuration.
  - All other supported instructions go to EXEC.
- **EXEC**
  - aluSrcA = 1.
  - R-type: aluSrcB = 00, aluFunc taken from func; goes to WB.
  - ADDI/LW/SW: aluSrcB = 10, `ALU_ADD`, bitXtend = 1.
  - ANDI/ORI: aluSrcB = 10, bitXtend = 0, `ALU_AND`/`ALU_OR`.
  - LW/SW go to MEM; I-type ALU ops go to WB.
  - BEQ/BNE: aluSrcB = 00, `ALU_SUB`, isBeq/isBne = 1, pcSrc = 01, bitXtend = 1, retire, then go to FETCH. The datapath gates pcWrite with the zero flag.
- **MEM**
  - memAddrSel = 1; LW drives memRead = 1, SW drives memWrite = 1.
  - Holds until memReady. SW then retires and goes to FETCH; LW goes to WB.
- **WB**
  - rfWriteEnable = 1.
  - rfWriteDataSel = 01 for LW, 00 otherwise.
  - rfWriteAddrSel = 1 for R-type, 0 otherwise.
  - Retires, then goes to FETCH.
- **Counter**
  - instCount increments on every retire.
  - Wraps from 2^CNT_W − 1 to 0.

## Timing
- While rst is high, all outputs are 0, instCount = 0 and state = FETCH; memRead rises in the first cycle after rst falls.
- rst asserted in any state (including mid-MEM with memRead held) returns the block to FETCH on the next edge. Any in-flight access is abandoned and retire is not pulsed.
- Latency with zero-wait memory (memReady held high):
  - J: 2 cycles.
  - BEQ/BNE: 3 cycles.
  - R-type/I-type: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Each wait cycle in FETCH or MEM adds one cycle.
- memReady is sampled only in FETCH and MEM and is ignored elsewhere.
- retire and invOpcode are combinational from state and the captured opcode, and last exactly one cycle.

## Configuration
- MC_INVOP_TRAP_EN defined: an invalid opcode goes DECODE → TRAP. TRAP drives all strobes 0, holds invOpcode = 1 continuously, and is left only via rst.
- Undefined: invalid opcode pulses invOpcode for one cycle in DECODE, does not retire, and returns to FETCH (treated as a NOP; PC was already advanced).

## Test plan
- Reset: rst high for 2 cycles → all outputs 0, instCount = 0, state = 0; first post-reset cycle has memRead = 1, memAddrSel = 0.
- R-type `MIPS_AND` with memReady = 1 → state sequence 0,1,2,4; in WB rfWriteEnable = 1, rfWriteAddrSel = 1, rfWriteDataSel = 00; in EXEC aluFunc = `ALU_AND`; instCount = 1.
- `MIPS_LW` with memReady low for 3 cycles in MEM → memRead held for 4 cycles, then WB with rfWriteDataSel = 01, rfWriteAddrSel = 0; total latency 8 cycles.
- `MIPS_BNE` → EXEC drives isBne = 1, aluFunc = `ALU_SUB`, pcSrc = 01; retire pulses and state returns to 0 after 3 cycles.
- Opc 0x2a, and separately opc 0 with func 0x2f:
  - Without MC_INVOP_TRAP_EN: invOpcode pulses once, instCount unchanged, back to FETCH.
  - With MC_INVOP_TRAP_EN: state = 5 with invOpcode held until rst.
- CNT_W = 4 with 17 back-to-back J instructions → instCount wraps to 1; rst mid-MEM of an SW → memWrite drops next cycle, instCount = 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshake.
// Optional MC_INVOP_TRAP_EN: invalid opcodes park the FSM in TRAP until reset.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opc,
  input  logic [5:0]       func,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             irWrite,
  output logic [1:0]       pcSrc,
  output logic             memAddrSel,
  output logic             memRead,
  output logic             memWrite,
  output logic             isJmp,
  output logic             isBeq,
  output logic             isBne,
  output logic [1:0]       rfWriteDataSel,
  output logic             rfWriteAddrSel,
  output logic             rfWriteEnable,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [2:0]       aluFunc,
  output logic             bitXtend,
  output logic             invOpcode,
  output logic             retire,
  output logic [CNT_W-1:0] instCount,
  output logic [2:0]       state
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] MIPS_ADD  = 6'h20;
  localparam logic [5:0] MIPS_SUB  = 6'h22;
  localparam logic [5:0] MIPS_AND  = 6'h24;
  localparam logic [5:0] MIPS_OR   = 6'h25;
  localparam logic [5:0] MIPS_SLT  = 6'h2a;
  localparam logic [5:0] MIPS_J    = 6'h02;
  localparam logic [5:0] MIPS_BEQ  = 6'h04;
  localparam logic [5:0] MIPS_BNE  = 6'h05;
  localparam logic [5:0] MIPS_ADDI = 6'h08;
  localparam logic [5:0] MIPS_ANDI = 6'h0c;
  localparam logic [5:0] MIPS_ORI  = 6'h0d;
  localparam logic [5:0] MIPS_LW   = 6'h23;
  localparam logic [5:0] MIPS_SW   = 6'h2b;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           r_state;
  logic [5:0]       r_opc;
  logic [5:0]       r_func;
  logic [CNT_W-1:0] r_cnt;

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_rtype;
  logic       w_rok;
  logic       w_lw;
  logic       w_sw;
  logic       w_beq;
  logic       w_bne;
  logic       w_j;
  logic       w_addi;
  logic       w_andi;
  logic       w_ori;
  logic       w_valid;
  logic [2:0] w_rfunc;

  // IR is only stable for decode in DECODE; afterwards use the captured copy
  assign w_op = (r_state == S_DECODE) ? opc : r_opc;
  assign w_fn = (r_state == S_DECODE) ? func : r_func;

  assign w_rtype = (w_op == 6'h00);
  assign w_rok   = w_rtype &&
                   (w_fn inside {MIPS_ADD, MIPS_SUB, MIPS_AND,
                                 MIPS_OR, MIPS_SLT});
  assign w_lw    = (w_op == MIPS_LW);
  assign w_sw    = (w_op == MIPS_SW);
  assign w_beq   = (w_op == MIPS_BEQ);
  assign w_bne   = (w_op == MIPS_BNE);
  assign w_j     = (w_op == MIPS_J);
  assign w_addi  = (w_op == MIPS_ADDI);
  assign w_andi  = (w_op == MIPS_ANDI);
  assign w_ori   = (w_op == MIPS_ORI);
  assign w_valid = w_rok | w_lw | w_sw | w_beq | w_bne |
                   w_j | w_addi | w_andi | w_ori;

  always_comb begin
    w_rfunc = ALU_ADD;
    unique case (1'b1)
      (w_fn == MIPS_SUB): w_rfunc = ALU_SUB;
      (w_fn == MIPS_AND): w_rfunc = ALU_AND;
      (w_fn == MIPS_OR):  w_rfunc = ALU_OR;
      (w_fn == MIPS_SLT): w_rfunc = ALU_SLT;
      default:            w_rfunc = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_opc   <= '0;
      r_func  <= '0;
      r_cnt   <= '0;
    end else begin
      if (retire) r_cnt <= r_cnt + 1'b1;
      unique case (r_state)
        S_FETCH: if (memReady) r_state <= S_DECODE;
        S_DECODE: begin
          r_opc  <= opc;
          r_func <= func;
          if (!w_valid)
`ifdef MC_INVOP_TRAP_EN
            r_state <= S_TRAP;
`else
            r_state <= S_FETCH;
`endif
          else if (w_j) r_state <= S_FETCH;
          else r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_lw || w_sw) r_state <= S_MEM;
          else if (w_beq || w_bne) r_state <= S_FETCH;
          else r_state <= S_WB;
        end
        S_MEM:
          if (memReady) r_state <= w_lw ? S_WB : S_FETCH;
        S_WB:   r_state <= S_FETCH;
        S_TRAP: r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pcWrite        = 1'b0;
    irWrite        = 1'b0;
    pcSrc          = 2'b00;
    memAddrSel     = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    isJmp          = 1'b0;
    isBeq          = 1'b0;
    isBne          = 1'b0;
    rfWriteDataSel = 2'b00;
    rfWriteAddrSel = 1'b0;
    rfWriteEnable  = 1'b0;
    aluSrcA        = 1'b0;
    aluSrcB        = 2'b00;
    aluFunc        = 3'b000;
    bitXtend       = 1'b0;
    invOpcode      = 1'b0;
    retire         = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_FETCH: begin
          memRead = 1'b1;
          if (memReady) begin
            irWrite = 1'b1;
            pcWrite = 1'b1;
            aluSrcB = 2'b01;
            aluFunc = ALU_ADD;
          end
        end
        S_DECODE: begin
          if (!w_valid) invOpcode = 1'b1;
          else if (w_j) begin
            isJmp   = 1'b1;
            pcWrite = 1'b1;
            pcSrc   = 2'b10;
            retire  = 1'b1;
          end
        end
        S_EXEC: begin
          aluSrcA = 1'b1;
          unique case (1'b1)
            w_rtype: aluFunc = w_rfunc;
            (w_addi || w_lw || w_sw): begin
              aluSrcB  = 2'b10;
              aluFunc  = ALU_ADD;
              bitXtend = 1'b1;
            end
            (w_andi || w_ori): begin
              aluSrcB = 2'b10;
              aluFunc = w_andi ? ALU_AND : ALU_OR;
            end
            (w_beq || w_bne): begin
              aluFunc  = ALU_SUB;
              isBeq    = w_beq;
              isBne    = w_bne;
              pcSrc    = 2'b01;
              bitXtend = 1'b1;
              retire   = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          memAddrSel = 1'b1;
          memRead    = w_lw;
          memWrite   = w_sw;
          retire     = w_sw && memReady;
        end
        S_WB: begin
          rfWriteEnable  = 1'b1;
          rfWriteDataSel = w_lw ? 2'b01 : 2'b00;
          rfWriteAddrSel = w_rtype;
          retire         = 1'b1;
        end
        S_TRAP: invOpcode = 1'b1;
        default: ;
      endcase
    end
  end

  assign state     = rst ? 3'd0 : r_state;
  assign instCount = rst ? '0 : r_cnt;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl (CNT_W=4 so counter wrap is reachable).
// Expected values are hand-derived from the instruction sequencing rules.
module tb_mips_multicycle_ctrl;

  localparam int CW = 4;

  localparam logic [2:0] E_AND = 3'b000;
  localparam logic [2:0] E_ADD = 3'b010;
  localparam logic [2:0] E_SUB = 3'b110;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opc;
  logic [5:0]    func;
  logic          memReady;
  logic          pcWrite, irWrite;
  logic [1:0]    pcSrc;
  logic          memAddrSel, memRead, memWrite;
  logic          isJmp, isBeq, isBne;
  logic [1:0]    rfWriteDataSel;
  logic          rfWriteAddrSel, rfWriteEnable;
  logic          aluSrcA;
  logic [1:0]    aluSrcB;
  logic [2:0]    aluFunc;
  logic          bitXtend, invOpcode, retire;
  logic [CW-1:0] instCount;
  logic [2:0]    state;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       mr, mw, rfwe, was, bne, xt, ret, asa;
    logic [1:0] wds, psrc, asb;
    logic [2:0] af;
  } snap_t;

  snap_t tr [32];
  int    lat, rets, invs, mrc;

  mips_multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func),
    .memReady(memReady),
    .pcWrite(pcWrite), .irWrite(irWrite), .pcSrc(pcSrc),
    .memAddrSel(memAddrSel), .memRead(memRead),
    .memWrite(memWrite), .isJmp(isJmp), .isBeq(isBeq),
    .isBne(isBne), .rfWriteDataSel(rfWriteDataSel),
    .rfWriteAddrSel(rfWriteAddrSel),
    .rfWriteEnable(rfWriteEnable), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluFunc(aluFunc),
    .bitXtend(bitXtend), .invOpcode(invOpcode),
    .retire(retire), .instCount(instCount), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    memReady = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Runs one instruction from FETCH; IR fields are scrambled after DECODE
  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input int waits);
    int w;
    w = waits;
    opc = op;
    func = fn;
    lat = 0;
    rets = 0;
    invs = 0;
    mrc = 0;
    for (int c = 0; c < 30; c++) begin
      if (state >= 3'd2) begin
        opc = 6'h3f;
        func = 6'h3f;
      end
      memReady = 1'b1;
      if (state == 3'd3 && w > 0) begin
        memReady = 1'b0;
        w--;
      end
      @(negedge clk);
      tr[c] = '{st: state, mr: memRead, mw: memWrite,
                rfwe: rfWriteEnable, was: rfWriteAddrSel,
                bne: isBne, xt: bitXtend, ret: retire,
                asa: aluSrcA, wds: rfWriteDataSel,
                psrc: pcSrc, asb: aluSrcB, af: aluFunc};
      lat++;
      rets += int'(retire);
      invs += int'(invOpcode);
      if (state == 3'd3 && memRead) mrc++;
      step();
      if (state == 3'd0) break;
    end
  endtask

  initial begin
    rst = 1'b1;
    opc = '0;
    func = '0;
    memReady = 1'b0;
    step();
    @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_memRead", 32'(memRead), 0);
    chk("rst_cnt", 32'(instCount), 0);
    chk("rst_pcWrite", 32'(pcWrite), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_memRead", 32'(memRead), 1);
    chk("post_rst_addrSel", 32'(memAddrSel), 0);
    chk("fetch_wait_irWrite", 32'(irWrite), 0);
    memReady = 1'b1;
    #1;
    chk("fetch_irWrite", 32'(irWrite), 1);
    chk("fetch_aluSrcB", 32'(aluSrcB), 1);
    chk("fetch_aluFunc", 32'(aluFunc), 32'(E_ADD));
    memReady = 1'b0;
    step();
    chk("fetch_hold", 32'(state), 0);

    run(6'h00, 6'h24, 0);
    chk("and_lat", lat, 4);
    chk("and_seq", {tr[0].st, tr[1].st, tr[2].st, tr[3].st},
        {3'd0, 3'd1, 3'd2, 3'd4});
    chk("and_aluFunc", 32'(tr[2].af), 32'(E_AND));
    chk("and_srcA", 32'(tr[2].asa), 1);
    chk("and_wb", {tr[3].rfwe, tr[3].was, tr[3].wds}, 4'b1100);
    chk("and_rets", rets, 1);
    chk("and_cnt", 32'(instCount), 1);

    run(6'h23, 6'h00, 3);
    chk("lw_lat", lat, 8);
    chk("lw_memRead_cycles", mrc, 4);
    chk("lw_wb", {tr[7].st, tr[7].rfwe, tr[7].was, tr[7].wds},
        {3'd4, 1'b1, 1'b0, 2'b01});
    chk("lw_cnt", 32'(instCount), 2);

    run(6'h05, 6'h00, 0);
    chk("bne_lat", lat, 3);
    chk("bne_exec", {tr[2].bne, tr[2].af, tr[2].psrc, tr[2].ret},
        {1'b1, E_SUB, 2'b01, 1'b1});
    chk("bne_cnt", 32'(instCount), 3);

    run(6'h2b, 6'h00, 0);
    chk("sw_lat", lat, 4);
    chk("sw_memWrite", {tr[3].mw, tr[3].ret}, 2'b11);
    run(6'h0d, 6'h00, 0);
    chk("ori_lat", lat, 4);
    chk("ori_exec", {tr[2].asb, tr[2].xt}, 3'b100);
    run(6'h02, 6'h00, 0);
    chk("j_lat", lat, 2);
    chk("j_cnt", 32'(instCount), 6);

    for (int k = 0; k < 2; k++) begin
      run(k == 0 ? 6'h2a : 6'h00, k == 0 ? 6'h00 : 6'h2f, 0);
`ifdef MC_INVOP_TRAP_EN
      chk("inv_trap_state", 32'(state), 5);
      chk("inv_trap_held", 32'(invOpcode), 1);
      chk("inv_trap_rets", rets, 0);
      do_reset();
`else
      chk("inv_lat", lat, 2);
      chk("inv_pulses", invs, 1);
      chk("inv_rets", rets, 0);
      chk("inv_cnt", 32'(instCount), 6);
`endif
    end

    do_reset();
    for (int k = 0; k < 17; k++) run(6'h02, 6'h00, 0);
    chk("wrap_cnt", 32'(instCount), 1);

    opc = 6'h2b;
    func = 6'h00;
    memReady = 1'b1;
    step();
    step();
    step();
    memReady = 1'b0;
    @(negedge clk);
    chk("sw_mid_state", 32'(state), 3);
    chk("sw_mid_memWrite", 32'(memWrite), 1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rstmem_memWrite", 32'(memWrite), 0);
    chk("rstmem_retire", 32'(retire), 0);
    chk("rstmem_state", 32'(state), 0);
    chk("rstmem_cnt", 32'(instCount), 0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("rstmem_refetch", {state, memRead}, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
